// File: rtl/debounce_bank.sv
// debounce_bank
// Multi-channel tick-based switch debouncer for the keypad/button front end.
// Each raw input is synchronised through two flops. It is then filtered against a
// shared prescaled tick, so a level change is accepted only after DB_TICKS
// consecutive ticks of disagreement. The block reports:
//   - stable levels,
//   - one-cycle press/release/hold strobes,
//   - a sticky per-channel press event that is cleared by an acknowledge.
//
// Ports
//   clk            in   1    system clock
//   n_reset        in   1    synchronous reset, active low
//   button_in      in   NCH  raw asynchronous switch inputs
//   ev_ack         in   NCH  level acknowledge, clears ev_pending[i]
//   db_out         out  NCH  debounced level
//   press_pulse    out  NCH  1-cycle strobe, db_out[i] became ACTIVE_LEVEL
//   release_pulse  out  NCH  1-cycle strobe, db_out[i] became idle
//   hold_pulse     out  NCH  1-cycle strobe after HOLD_TICKS ticks of press
//   hold_active    out  NCH  high from hold_pulse until release
//   ev_pending     out  NCH  sticky press event
//   any_active     out  1    some channel is pressed
//   tick_out       out  1    prescaler tick, one cycle every TICK_DIV
module debounce_bank #(
    parameter int unsigned NCH          = 4,
    parameter int unsigned TICK_DIV     = 27000,
    parameter int unsigned DB_TICKS     = 20,
    parameter int unsigned HOLD_TICKS   = 1000,
    parameter logic        ACTIVE_LEVEL = 1'b1
) (
    input  logic           clk,
    input  logic           n_reset,
    input  logic [NCH-1:0] button_in,
    input  logic [NCH-1:0] ev_ack,
    output logic [NCH-1:0] db_out,
    output logic [NCH-1:0] press_pulse,
    output logic [NCH-1:0] release_pulse,
    output logic [NCH-1:0] hold_pulse,
    output logic [NCH-1:0] hold_active,
    output logic [NCH-1:0] ev_pending,
    output logic           any_active,
    output logic           tick_out
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CW = $clog2(DB_TICKS + 1);
    localparam int unsigned HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0]  DB_LAST    = CW'(DB_TICKS - 1);
    localparam logic [HW-1:0]  HOLD_LAST  = HW'((HOLD_TICKS > 0) ? HOLD_TICKS - 1 : 0);
    localparam logic [NCH-1:0] IDLE_V     = {NCH{~ACTIVE_LEVEL}};
    localparam logic [NCH-1:0] ACTIVE_V   = {NCH{ACTIVE_LEVEL}};
    localparam bit             HOLD_EN    = (HOLD_TICKS > 0);

    logic [PW-1:0]  presc_q, presc_d;
    logic           tick;

    logic [NCH-1:0] s1_q, s2_q;
    logic [NCH-1:0] db_q, db_d;
    logic [CW-1:0]  cnt_q [NCH];
    logic [CW-1:0]  cnt_d [NCH];

    logic [NCH-1:0] press_q, press_d;
    logic [NCH-1:0] release_q, release_d;
    logic [NCH-1:0] hold_p_q, hold_p_d;
    logic [NCH-1:0] hold_a_q, hold_a_d;
    logic [HW-1:0]  hcnt_q [NCH];
    logic [HW-1:0]  hcnt_d [NCH];
    logic [NCH-1:0] ev_q, ev_d;

    assign tick    = (presc_q == PRESC_LAST);
    assign presc_d = tick ? '0 : presc_q + PW'(1);

    always_comb begin
        db_d      = db_q;
        cnt_d     = cnt_q;
        press_d   = '0;
        release_d = '0;
        hold_p_d  = '0;
        hold_a_d  = hold_a_q;
        hcnt_d    = hcnt_q;
        ev_d      = '0;

        for (int i = 0; i < NCH; i++) begin
            // Any sample agreeing with the current level restarts the filter.
            if (s2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick) begin
                if (cnt_q[i] == DB_LAST) begin
                    db_d[i]  = s2_q[i];
                    cnt_d[i] = '0;
                    if (s2_q[i] == ACTIVE_LEVEL) press_d[i]   = 1'b1;
                    else                         release_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end

            // The hold counter stays frozen once hold_active is set; it restarts
            // on either edge of db_out.
            if (!HOLD_EN) begin
                hcnt_d[i]   = '0;
                hold_a_d[i] = 1'b0;
            end else if (press_d[i] || release_d[i]) begin
                hcnt_d[i]   = '0;
                hold_a_d[i] = 1'b0;
            end else if (db_q[i] != ACTIVE_LEVEL) begin
                hcnt_d[i]   = '0;
            end else if (!hold_a_q[i] && tick) begin
                hcnt_d[i] = hcnt_q[i] + HW'(1);
                if (hcnt_q[i] == HOLD_LAST) begin
                    hold_a_d[i] = 1'b1;
                    hold_p_d[i] = 1'b1;
                end
            end

            // A new press wins over an acknowledge sampled on the same edge.
            ev_d[i] = press_d[i] | (ev_q[i] & ~ev_ack[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            presc_q   <= '0;
            s1_q      <= IDLE_V;
            s2_q      <= IDLE_V;
            db_q      <= IDLE_V;
            press_q   <= '0;
            release_q <= '0;
            hold_p_q  <= '0;
            hold_a_q  <= '0;
            ev_q      <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i]  <= '0;
                hcnt_q[i] <= '0;
            end
        end else begin
            presc_q   <= presc_d;
            s1_q      <= button_in;
            s2_q      <= s1_q;
            db_q      <= db_d;
            press_q   <= press_d;
            release_q <= release_d;
            hold_p_q  <= hold_p_d;
            hold_a_q  <= hold_a_d;
            ev_q      <= ev_d;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i]  <= cnt_d[i];
                hcnt_q[i] <= hcnt_d[i];
            end
        end
    end

    assign db_out        = db_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign hold_pulse    = hold_p_q;
    assign hold_active   = hold_a_q;
    assign ev_pending    = ev_q;
    assign any_active    = |(~(db_q ^ ACTIVE_V));
    assign tick_out      = tick;

endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank
// Bench for debounce_bank with NCH=2, TICK_DIV=4, DB_TICKS=3, HOLD_TICKS=5.
// A cycle-level reference model tracks every output on every cycle. Hand-written
// sequences and a segment table check the timing corners. A randomized phase
// then runs against the model.
module tb_debounce_bank;

    localparam int TD   = 4;
    localparam int DB   = 3;
    localparam int HOLD = 5;

    logic       clk;
    logic       n_reset;
    logic [1:0] button_in;
    logic [1:0] ev_ack;
    logic [1:0] db_out, press_pulse, release_pulse, hold_pulse, hold_active, ev_pending;
    logic       any_active, tick_out;

    debounce_bank #(
        .NCH(2), .TICK_DIV(TD), .DB_TICKS(DB), .HOLD_TICKS(HOLD), .ACTIVE_LEVEL(1'b1)
    ) dut (
        .clk(clk), .n_reset(n_reset), .button_in(button_in), .ev_ack(ev_ack),
        .db_out(db_out), .press_pulse(press_pulse), .release_pulse(release_pulse),
        .hold_pulse(hold_pulse), .hold_active(hold_active), .ev_pending(ev_pending),
        .any_active(any_active), .tick_out(tick_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Reference model. The synchroniser is the raw sample seen two edges ago.
    // A level is accepted on the DB-th tick in a row on which the synchronised
    // input disagrees with the current debounced level.
    int       m_pc;
    bit [1:0] m_h0, m_h1;
    int       m_streak [2];
    int       m_held   [2];
    bit [1:0] m_db, m_pp, m_rp, m_hp, m_ha, m_ev;

    always @(posedge clk) begin
        bit tk;
        bit seen;
        if (!n_reset) begin
            m_pc = 0; m_h0 = '0; m_h1 = '0;
            m_db = '0; m_pp = '0; m_rp = '0; m_hp = '0; m_ha = '0; m_ev = '0;
            for (int c = 0; c < 2; c++) begin
                m_streak[c] = 0;
                m_held[c]   = 0;
            end
        end else begin
            tk   = (m_pc == TD - 1);
            m_pc = (m_pc + 1) % TD;
            for (int c = 0; c < 2; c++) begin
                seen    = m_h1[c];
                m_pp[c] = 1'b0; m_rp[c] = 1'b0; m_hp[c] = 1'b0;
                if (seen == m_db[c]) m_streak[c] = 0;
                else if (tk) begin
                    m_streak[c]++;
                    if (m_streak[c] == DB) begin
                        m_db[c] = seen;
                        m_streak[c] = 0;
                        m_pp[c] = seen;
                        m_rp[c] = !seen;
                    end
                end
                if (m_pp[c] || m_rp[c]) begin
                    m_held[c] = 0;
                    m_ha[c]   = 1'b0;
                end else if (m_db[c] && !m_ha[c] && tk) begin
                    m_held[c]++;
                    if (m_held[c] == HOLD) begin
                        m_ha[c] = 1'b1;
                        m_hp[c] = 1'b1;
                    end
                end else if (!m_db[c]) begin
                    m_held[c] = 0;
                end
                m_ev[c] = m_pp[c] | (m_ev[c] & ~ev_ack[c]);
            end
            m_h1 = m_h0;
            m_h0 = button_in;
        end
    end

    always @(negedge clk) begin
        logic [13:0] got, exp;
        if (chk_en) begin
            got = {db_out, press_pulse, release_pulse, hold_pulse, hold_active,
                   ev_pending, any_active, tick_out};
            exp = {m_db, m_pp, m_rp, m_hp, m_ha, m_ev, |m_db, (m_pc == TD - 1)};
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL model_cycle t=%0t got=%b exp=%b (db,pp,rp,hp,ha,ev,any,tick)",
                         $time, got, exp);
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic check_rng(input string name, input int got, input int lo, input int hi);
        tests++;
        if (got < lo || got > hi) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d..%0d", name, got, lo, hi);
        end
    endtask

    int cp [2];
    int cr [2];
    int ch [2];

    task automatic clr_counts();
        for (int c = 0; c < 2; c++) begin
            cp[c] = 0; cr[c] = 0; ch[c] = 0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            cp[c] += int'(press_pulse[c]);
            cr[c] += int'(release_pulse[c]);
            ch[c] += int'(hold_pulse[c]);
        end
    endtask

    typedef struct {
        logic [1:0] btn;
        int         cyc;
        logic [1:0] exp_db;
        logic [1:0] exp_press;
        logic [1:0] exp_rel;
        logic [1:0] exp_hold;
    } seg_t;

    seg_t tbl [8];

    initial begin
        int n, lat, t1, t2, seg_left, rst_left;
        bit seen;

        tbl[0] = '{2'b01, 40, 2'b01, 2'b01, 2'b00, 2'b01};
        tbl[1] = '{2'b00, 40, 2'b00, 2'b00, 2'b01, 2'b00};
        tbl[2] = '{2'b10,  8, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[3] = '{2'b00, 40, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[4] = '{2'b11, 40, 2'b11, 2'b11, 2'b00, 2'b11};
        tbl[5] = '{2'b01, 40, 2'b01, 2'b00, 2'b10, 2'b00};
        tbl[6] = '{2'b10, 40, 2'b10, 2'b10, 2'b01, 2'b10};
        tbl[7] = '{2'b00, 40, 2'b00, 2'b00, 2'b10, 2'b00};

        // Reset with both buttons already pressed
        n_reset = 1'b0; button_in = 2'b11; ev_ack = 2'b00;
        clr_counts();
        step();
        chk_en = 1'b1;
        repeat (4) step();
        check("reset_outputs",
              int'({db_out, press_pulse, release_pulse, hold_pulse, hold_active,
                    ev_pending, any_active, tick_out}), 0);
        n_reset = 1'b1;
        lat = -1; t1 = -1; t2 = -1;
        for (n = 1; n <= 30; n++) begin
            step();
            if (db_out[0] && lat < 0) lat = n;
            if (tick_out) begin
                if (t1 < 0) t1 = n;
                else if (t2 < 0) t2 = n;
            end
        end
        check_rng("reset_rise_latency", lat, 11, 14);
        check("tick_period", t2 - t1, TD);
        button_in = 2'b00;
        repeat (40) step();
        ev_ack = 2'b11; step(); ev_ack = 2'b00; step();
        check("ack_clears_both", int'(ev_pending), 0);

        // Clean press on ch0 with acknowledge
        clr_counts(); lat = -1;
        button_in = 2'b01;
        for (n = 1; n <= 40; n++) begin
            step();
            if (press_pulse[0] && lat < 0) lat = n;
        end
        check("clean_press_count", cp[0], 1);
        check_rng("clean_press_latency", lat, 11, 14);
        check("clean_db", int'(db_out[0]), 1);
        check("clean_ev_pending", int'(ev_pending[0]), 1);
        ev_ack = 2'b01; step(); ev_ack = 2'b00;
        check("ev_ack_clears", int'(ev_pending[0]), 0);
        button_in = 2'b00;
        repeat (40) step();

        // Bounce on ch0, then settle high
        clr_counts();
        for (int k = 0; k < 12; k++) begin
            button_in = (k % 2 == 0) ? 2'b01 : 2'b00;
            repeat (5) step();
        end
        check("bounce_no_strobe", cp[0] + cr[0], 0);
        clr_counts(); lat = -1;
        button_in = 2'b01;
        for (n = 1; n <= 40; n++) begin
            step();
            if (press_pulse[0] && lat < 0) lat = n;
        end
        check("bounce_press_count", cp[0], 1);
        check_rng("bounce_settle_latency", lat, 11, 14);
        button_in = 2'b00;
        repeat (40) step();
        ev_ack = 2'b11; step(); ev_ack = 2'b00;

        // Long press on ch1, then release
        clr_counts(); t1 = -1; t2 = -1;
        button_in = 2'b10;
        for (n = 1; n <= 100; n++) begin
            step();
            if (press_pulse[1] && t1 < 0) t1 = n;
            if (hold_pulse[1]  && t2 < 0) t2 = n;
        end
        check("hold_count", ch[1], 1);
        check("hold_delay", t2 - t1, HOLD * TD);
        check("hold_active_kept", int'(hold_active[1]), 1);
        button_in = 2'b00; seen = 1'b0;
        for (n = 1; n <= 40 && !seen; n++) begin
            step();
            if (release_pulse[1]) begin
                seen = 1'b1;
                check("hold_active_clr_on_release", int'(hold_active[1]), 0);
            end
        end
        check("release_seen", int'(seen), 1);
        ev_ack = 2'b11; step(); ev_ack = 2'b00;

        // Short press on ch0
        clr_counts();
        button_in = 2'b01; repeat (8) step();
        button_in = 2'b00; repeat (30) step();
        check("short_no_strobe", cp[0] + cr[0] + ch[0], 0);
        check("short_db", int'(db_out[0]), 0);
        check("short_ev", int'(ev_pending[0]), 0);

        // Acknowledge coinciding with the press, then reset in the middle of a hold
        ev_ack = 2'b01; button_in = 2'b01; seen = 1'b0;
        for (n = 1; n <= 40 && !seen; n++) begin
            step();
            if (press_pulse[0]) begin
                seen = 1'b1;
                check("set_wins_over_ack", int'(ev_pending[0]), 1);
            end
        end
        check("ack_press_seen", int'(seen), 1);
        ev_ack = 2'b00; seen = 1'b0;
        for (n = 1; n <= 40 && !seen; n++) begin
            step();
            if (hold_active[0]) seen = 1'b1;
        end
        check("hold_before_reset", int'(seen), 1);
        clr_counts();
        n_reset = 1'b0;
        step();
        check("midhold_reset_outputs",
              int'({db_out, press_pulse, release_pulse, hold_pulse, hold_active,
                    ev_pending, any_active, tick_out}), 0);
        step();
        n_reset = 1'b1; button_in = 2'b00;
        repeat (20) step();
        check("midhold_no_release", cr[0] + cr[1], 0);
        repeat (20) step();

        // Segment table
        for (int r = 0; r < 8; r++) begin
            button_in = tbl[r].btn;
            clr_counts();
            repeat (tbl[r].cyc) step();
            check($sformatf("tbl%0d_db", r), int'(db_out), int'(tbl[r].exp_db));
            check($sformatf("tbl%0d_press", r), cp[0] + 4 * cp[1],
                  int'(tbl[r].exp_press[0]) + 4 * int'(tbl[r].exp_press[1]));
            check($sformatf("tbl%0d_release", r), cr[0] + 4 * cr[1],
                  int'(tbl[r].exp_rel[0]) + 4 * int'(tbl[r].exp_rel[1]));
            check($sformatf("tbl%0d_hold", r), ch[0] + 4 * ch[1],
                  int'(tbl[r].exp_hold[0]) + 4 * int'(tbl[r].exp_hold[1]));
        end

        // Randomized traffic against the model
        seg_left = 0; rst_left = 0;
        for (int k = 0; k < 3000; k++) begin
            if (seg_left == 0) begin
                button_in = 2'($urandom);
                seg_left  = $urandom_range(1, 25);
            end
            seg_left--;
            ev_ack = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
            if (rst_left > 0) rst_left--;
            else if ($urandom_range(0, 399) == 0) rst_left = 2;
            n_reset = (rst_left == 0);
            step();
        end
        n_reset = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
